san_timer_irq: RTL and testbench
================================

# san_timer_irq

Parametrised multi-channel periodic/one-shot timer with maskable interrupt aggregation. It is the successor to the single-channel fixed-period 1 s counter. It sits beside the AXI4-Lite slave register file and snoops the write strobe, the word address and the write data. Each channel counts `S_AXI_ACLK` cycles up to a software-programmed period and raises a sticky status bit. The masked OR of the status bits drives one level interrupt to the PS.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32: counter, period and write-data width (16..32).
- `NUM_CH`, 2: number of timer channels (1..4).
- `ADDR_W`, 3: width of the word-index write address.

- `S_AXI_ACLK`  in  1: single clock, all logic rising-edge.
- `S_AXI_ARESETN`  in  1: reset, asynchronous assert, active-low.
- `slv_reg_wren`  in  1: one-cycle register write strobe from the AXI slave.
- `axi_awaddr`  in  ADDR_W: word index of the write.
- `S_AXI_WDATA`  in  C_S_AXI_DATA_WIDTH: write data.
- `COUNT_SAN`  out  NUM_CH*C_S_AXI_DATA_WIDTH: per-channel current count; channel c is in bits [c*W +: W].
- `IRQ_STATUS`  out  NUM_CH: sticky per-channel terminal flags.
- `EXT_IRQ_PULSE`  out  NUM_CH: one-cycle pulse per terminal event, unmasked.
- `EXT_IRQ`  out  1: registered level interrupt, equal to |(IRQ_STATUS & mask).
- `OVF_CNT`  out  NUM_CH*8: per-channel missed-interrupt counters (see Configuration).

## Operation
- Register map, by word index on `axi_awaddr`; writes take effect at the edge where `slv_reg_wren` is 1:
  - 0 CTRL: bit c = EN[c]; bit 8+c = ONESHOT[c] (0 = periodic).
  - 1 STATUS: write-1-to-clear, per bit.
  - 2 MASK: bit c enables channel c onto `EXT_IRQ`.
  - 4+c PERIOD[c].
  - Any other index is ignored.
- Reset values: all registers, counters and outputs are 0.
- Channel c, each cycle:
  - EN=0 or PERIOD=0: the count is loaded with 0 and no event occurs.
  - Otherwise, with a terminal condition of count >= PERIOD-1: the count loads 0, STATUS[c] is set, EXT_IRQ_PULSE[c]=1, and if ONESHOT[c]=1 then EN[c] clears.
  - Otherwise the count increments by 1.
- The comparison uses >=. When PERIOD is rewritten below the current count, the terminal event fires on the next cycle and the count does not wrap.
- PERIOD=1 produces an event every cycle while enabled.
- Simultaneous events:
  - Hardware set and W1C of the same STATUS bit in one cycle: the set wins.
  - A CTRL write in the same cycle as a one-shot auto-clear: the software value wins.
  - A PERIOD write in the same cycle as terminal: the count loads 0 and the new period applies to the next run.
- Asynchronous reset mid-count clears everything immediately. No event is generated by the reset.

## Timing
- The count register updates one cycle after the EN write edge. The first increment is at edge +1, so count=1 one cycle after EN is written.
- A periodic channel with period P produces events exactly P cycles apart.
- Terminal sampled at edge N: STATUS, EXT_IRQ_PULSE and the count reset all take effect at edge N, and EXT_IRQ rises at edge N+1.
- W1C or MASK clear at edge N: EXT_IRQ falls at edge N+1, provided no other masked bit remains set.
- EXT_IRQ_PULSE is high for exactly one cycle per event, independent of MASK.

## Configuration
- `SAN_TIMER_OVF_CNT_EN` defined:
  - Each channel has an 8-bit counter that increments when a terminal event occurs while STATUS[c] is already 1.
  - The counter saturates at 255.
  - It clears in the cycle that software W1C-clears STATUS[c]. If a hardware set coincides with that clear, the counter still clears.
- `SAN_TIMER_OVF_CNT_EN` not defined: no counter logic is built and `OVF_CNT` is tied to 0.

## Test plan
- Reset, then write PERIOD[0]=5, MASK=1, CTRL=0x1 → EXT_IRQ_PULSE[0] at 5-cycle intervals, STATUS[0]=1, EXT_IRQ high one cycle after the first pulse; COUNT_SAN[0] sequence is 1,2,3,4,0.
- CTRL=0x101 with PERIOD[0]=3 (one-shot) → a single pulse, then EN[0] reads 0, count holds at 0, and no further pulses occur over 20 cycles.
- Channel running with PERIOD=100; at count=50 write PERIOD=10 → pulse on the next cycle, then a 10-cycle period.
- STATUS W1C written in the same cycle as a channel-1 terminal event → STATUS[1] stays 1 and EXT_IRQ stays high.
- MASK=0 with periodic events → EXT_IRQ stays 0 while IRQ_STATUS and the pulses still occur; then MASK=1 → EXT_IRQ rises one cycle later.
- With the macro defined: PERIOD=2, never clear STATUS for 600 cycles → OVF_CNT saturates at 255; then W1C → OVF_CNT=0. Without the macro, OVF_CNT stays 0. Also assert reset mid-count → all outputs are 0 asynchronously.

Source files
------------

// File: rtl/san_timer_irq.sv
// Multi-channel periodic/one-shot timer that snoops AXI4-Lite register writes and aggregates
// masked sticky status into one level interrupt. Define SAN_TIMER_OVF_CNT_EN for missed-IRQ counters.
module san_timer_irq #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned NUM_CH             = 2,
  parameter int unsigned ADDR_W             = 3
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESETN,
  input  logic                                 slv_reg_wren,
  input  logic [ADDR_W-1:0]                    axi_awaddr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  output logic [NUM_CH*C_S_AXI_DATA_WIDTH-1:0] COUNT_SAN,
  output logic [NUM_CH-1:0]                    IRQ_STATUS,
  output logic [NUM_CH-1:0]                    EXT_IRQ_PULSE,
  output logic                                 EXT_IRQ,
  output logic [NUM_CH*8-1:0]                  OVF_CNT
);

  localparam int unsigned W = C_S_AXI_DATA_WIDTH;

  logic              wr_ctrl;
  logic              wr_status;
  logic              wr_mask;
  logic [NUM_CH-1:0] wr_period;
  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] w1c;

  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] oneshot_q, oneshot_d;
  logic [NUM_CH-1:0] status_q, status_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] pulse_q;
  logic              irq_q;
  logic [W-1:0]      count_q  [NUM_CH];
  logic [W-1:0]      count_d  [NUM_CH];
  logic [W-1:0]      period_q [NUM_CH];
  logic [W-1:0]      period_d [NUM_CH];

  assign wr_ctrl   = slv_reg_wren && (axi_awaddr == ADDR_W'(0));
  assign wr_status = slv_reg_wren && (axi_awaddr == ADDR_W'(1));
  assign wr_mask   = slv_reg_wren && (axi_awaddr == ADDR_W'(2));

  // Terminal uses >= so a period rewritten below the running count fires next cycle.
  always_comb begin
    wr_period = '0;
    term      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_period[c] = slv_reg_wren && (axi_awaddr == ADDR_W'(4 + c));
      term[c]      = en_q[c] && (period_q[c] != '0) && (count_q[c] >= period_q[c] - W'(1));
      count_d[c]   = (en_q[c] && (period_q[c] != '0) && !term[c]) ? count_q[c] + W'(1) : '0;
      period_d[c]  = wr_period[c] ? S_AXI_WDATA : period_q[c];
    end
  end

  // Hardware set beats W1C; a software CTRL write beats one-shot auto-clear.
  always_comb begin
    w1c       = wr_status ? S_AXI_WDATA[NUM_CH-1:0] : '0;
    status_d  = (status_q & ~w1c) | term;
    en_d      = en_q & ~(term & oneshot_q);
    oneshot_d = oneshot_q;
    if (wr_ctrl) begin
      en_d      = S_AXI_WDATA[NUM_CH-1:0];
      oneshot_d = S_AXI_WDATA[8 +: NUM_CH];
    end
    mask_d = wr_mask ? S_AXI_WDATA[NUM_CH-1:0] : mask_q;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      en_q      <= '0;
      oneshot_q <= '0;
      status_q  <= '0;
      mask_q    <= '0;
      pulse_q   <= '0;
      irq_q     <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        count_q[c]  <= '0;
        period_q[c] <= '0;
      end
    end else begin
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      status_q  <= status_d;
      mask_q    <= mask_d;
      pulse_q   <= term;
      irq_q     <= |(status_q & mask_q);
      for (int c = 0; c < NUM_CH; c++) begin
        count_q[c]  <= count_d[c];
        period_q[c] <= period_d[c];
      end
    end
  end

  always_comb begin
    COUNT_SAN = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      COUNT_SAN[c*W +: W] = count_q[c];
    end
  end

  assign IRQ_STATUS    = status_q;
  assign EXT_IRQ_PULSE = pulse_q;
  assign EXT_IRQ       = irq_q;

`ifdef SAN_TIMER_OVF_CNT_EN
  logic [7:0] ovf_q [NUM_CH];
  logic [7:0] ovf_d [NUM_CH];

  // Clear on W1C wins even over a coincident event; otherwise count events hitting a set bit.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ovf_d[c] = ovf_q[c];
      if (w1c[c]) begin
        ovf_d[c] = '0;
      end else if (term[c] && status_q[c] && (ovf_q[c] != 8'hff)) begin
        ovf_d[c] = ovf_q[c] + 8'd1;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ovf_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        ovf_q[c] <= ovf_d[c];
      end
    end
  end

  always_comb begin
    OVF_CNT = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      OVF_CNT[c*8 +: 8] = ovf_q[c];
    end
  end
`else
  assign OVF_CNT = '0;
`endif

endmodule

// File: tb/tb_san_timer_irq.sv
// Directed self-checking bench for san_timer_irq (2 channels, 32-bit).
module tb_san_timer_irq;

  logic        clk;
  logic        rst_n;
  logic        wren;
  logic [2:0]  awaddr;
  logic [31:0] wdata;
  logic [63:0] count_san;
  logic [1:0]  irq_status;
  logic [1:0]  irq_pulse;
  logic        ext_irq;
  logic [15:0] ovf_cnt;

  int n_total = 0;
  int n_bad   = 0;

`ifdef SAN_TIMER_OVF_CNT_EN
  localparam logic [7:0] ExpSat = 8'd255;
`else
  localparam logic [7:0] ExpSat = 8'd0;
`endif

  san_timer_irq #(
    .C_S_AXI_DATA_WIDTH(32),
    .NUM_CH            (2),
    .ADDR_W            (3)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .slv_reg_wren (wren),
    .axi_awaddr   (awaddr),
    .S_AXI_WDATA  (wdata),
    .COUNT_SAN    (count_san),
    .IRQ_STATUS   (irq_status),
    .EXT_IRQ_PULSE(irq_pulse),
    .EXT_IRQ      (ext_irq),
    .OVF_CNT      (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wren   = 1'b1;
    awaddr = 3'(a);
    wdata  = d;
    step();
    wren   = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    wren   = 1'b0;
    awaddr = '0;
    wdata  = '0;
    #2;
    check("rst_count", count_san, 64'd0);
    check("rst_status", irq_status, 2'b00);
    check("rst_irq", ext_irq, 1'b0);
    check("rst_ovf", ovf_cnt, 16'd0);
    #21 rst_n = 1'b1;

    // Periodic channel 0, period 5, masked in
    wr(4, 5);
    wr(2, 1);
    wr(0, 1);
    check("en_edge_count", count_san[31:0], 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      check("per_count", count_san[31:0], i % 5);
      check("per_pulse", irq_pulse, {1'b0, (i % 5) == 0});
      check("per_status", irq_status, {1'b0, i >= 5});
      check("per_irq", ext_irq, i >= 6);
    end
    wr(0, 0);
    wr(1, 3);
    check("w1c_status", irq_status, 2'b00);
    check("w1c_irq_lag", ext_irq, 1'b1);
    step();
    check("w1c_irq_fall", ext_irq, 1'b0);
    check("dis_count", count_san[31:0], 0);

    // One-shot, period 3
    wr(4, 3);
    wr(0, 32'h101);
    for (int i = 1; i <= 23; i++) begin
      step();
      check("os_count", count_san[31:0], (i < 3) ? i : 0);
      check("os_pulse", irq_pulse, {1'b0, i == 3});
    end
    check("os_status", irq_status, 2'b01);
    wr(1, 1);

    // Period shrunk below running count
    wr(4, 100);
    wr(0, 1);
    repeat (50) step();
    check("shrink_at50", count_san[31:0], 50);
    wr(4, 10);
    check("shrink_cnt51", count_san[31:0], 51);
    check("shrink_nopulse", irq_pulse, 2'b00);
    step();
    check("shrink_term_cnt", count_san[31:0], 0);
    check("shrink_term_pulse", irq_pulse, 2'b01);
    for (int i = 1; i <= 10; i++) begin
      step();
      check("shrink_cnt", count_san[31:0], i % 10);
      check("shrink_pulse", irq_pulse, {1'b0, i == 10});
    end
    wr(0, 0);
    wr(1, 3);
    step();

    // W1C coincident with channel-1 terminal: set wins
    wr(2, 3);
    wr(5, 4);
    wr(0, 2);
    repeat (7) step();
    check("coin_status_pre", irq_status, 2'b10);
    wr(1, 2);
    check("coin_pulse", irq_pulse, 2'b10);
    check("coin_status", irq_status, 2'b10);
    check("coin_irq", ext_irq, 1'b1);
    step();
    check("coin_irq_hold", ext_irq, 1'b1);
    check("coin_cnt1", count_san[63:32], 1);
    wr(1, 2);
    check("clr1_status", irq_status, 2'b00);
    wr(0, 0);
    check("clr1_irq", ext_irq, 1'b0);

    // Masked-off events, then unmask
    wr(2, 0);
    wr(4, 3);
    wr(0, 1);
    for (int i = 1; i <= 7; i++) begin
      step();
      check("mask0_pulse", irq_pulse, {1'b0, (i % 3) == 0});
      check("mask0_status", irq_status, {1'b0, i >= 3});
      check("mask0_irq", ext_irq, 1'b0);
    end
    wr(2, 1);
    check("unmask_lag", ext_irq, 1'b0);
    step();
    check("unmask_irq", ext_irq, 1'b1);
    wr(0, 0);
    wr(1, 3);
    step();

    // Missed-interrupt counter saturation and clear
    wr(4, 2);
    wr(0, 1);
    repeat (600) step();
    check("ovf_sat", ovf_cnt[7:0], ExpSat);
    check("ovf_ch1", ovf_cnt[15:8], 8'd0);
    wr(1, 1);
    check("ovf_clr", ovf_cnt, 16'd0);
    check("irq_pre_rst", ext_irq, 1'b1);

    // Asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    check("arst_count", count_san, 64'd0);
    check("arst_status", irq_status, 2'b00);
    check("arst_pulse", irq_pulse, 2'b00);
    check("arst_irq", ext_irq, 1'b0);
    check("arst_ovf", ovf_cnt, 16'd0);
    #10 rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_count", count_san, 64'd0);
    check("post_rst_pulse", irq_pulse, 2'b00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
